// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall controller.
// Opcode/funct encodings, FSM states and the packed control-word type.
// Control-word presets cover the four per-cycle pipeline actions.
package pipe_stall_ctrl_pkg;

  localparam logic [5:0] LOAD_OP_DEF  = 6'h23;
  localparam logic [5:0] OP_SPECIAL   = 6'h00;
  localparam logic [5:0] MD_FUNCT_LO  = 6'h18;
  localparam logic [5:0] MD_FUNCT_HI  = 6'h1B;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic id_we;
    logic exe_we;
    logic mem_we;
    logic wb_we;
    logic id_flush;
    logic exe_bubble;
    logic md_start;
  } ctrl_t;

  // Every stage advances normally.
  localparam ctrl_t CTRL_GO = '{pc_we: 1'b1, id_we: 1'b1, exe_we: 1'b1, mem_we: 1'b1,
                                wb_we: 1'b1, id_flush: 1'b0, exe_bubble: 1'b0, md_start: 1'b0};
  // Whole pipeline frozen (memory wait).
  localparam ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, id_we: 1'b0, exe_we: 1'b0, mem_we: 1'b0,
                                    wb_we: 1'b0, id_flush: 1'b0, exe_bubble: 1'b0, md_start: 1'b0};
  // Front end held, bubble injected into EXE, back end drains.
  localparam ctrl_t CTRL_HOLD_FRONT = '{pc_we: 1'b0, id_we: 1'b0, exe_we: 1'b1, mem_we: 1'b1,
                                        wb_we: 1'b1, id_flush: 1'b0, exe_bubble: 1'b1, md_start: 1'b0};
  // Taken branch: advance, but squash the wrong-path ID and EXE contents.
  localparam ctrl_t CTRL_FLUSH = '{pc_we: 1'b1, id_we: 1'b1, exe_we: 1'b1, mem_we: 1'b1,
                                   wb_we: 1'b1, id_flush: 1'b1, exe_bubble: 1'b1, md_start: 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Hazard decode: flags load-use between EXE and ID, and a mult/div op in ID.
// Latency: purely combinational.
// Backpressure: none; the results feed the stall FSM in the same cycle.
module pipe_stall_ctrl_hazard_detect
  import pipe_stall_ctrl_pkg::*;
#(
  parameter logic [5:0] LOAD_OP = LOAD_OP_DEF
) (
  input  logic [31:0] id_inst,
  input  logic [31:0] exe_inst,
  output logic        load_use,
  output logic        is_md
);

  logic [4:0] exe_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       unused_bits;

  assign exe_rt = exe_inst[20:16];
  assign id_rs  = id_inst[25:21];
  assign id_rt  = id_inst[20:16];

  // A load into $0 never creates a real dependency.
  always_comb begin
    load_use = (exe_inst[31:26] == LOAD_OP) && (exe_rt != 5'd0) &&
               ((exe_rt == id_rs) || (exe_rt == id_rt));
  end

  // mult/multu/div/divu are SPECIAL-opcode ops with funct in a contiguous range.
  always_comb begin
    is_md = (id_inst[31:26] == OP_SPECIAL) &&
            (id_inst[5:0] >= MD_FUNCT_LO) && (id_inst[5:0] <= MD_FUNCT_HI);
  end

  assign unused_bits = ^{id_inst[15:6], exe_inst[25:21], exe_inst[15:0]};

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer driving every stage register enable.
// Latency: enables and strobes are combinational; FSM, timer and counters register.
// Backpressure: memory wait freezes all stages; load-use and mult/div hold the front end.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter logic [5:0] LOAD_OP     = LOAD_OP_DEF,
  parameter int         MEM_TIMEOUT = 16,
  parameter int         TMR_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_inst,
  input  logic [31:0] exe_inst,
  input  logic        exe_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        md_busy,
  input  logic        md_done,
  output logic        pc_we,
  output logic        id_we,
  output logic        exe_we,
  output logic        mem_we,
  output logic        wb_we,
  output logic        id_flush,
  output logic        exe_bubble,
  output logic        md_start,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic             md_done_seen;
  ctrl_t            ctrl;
  logic             load_use;
  logic             is_md;
  logic             mem_stall;
  logic             md_fin;
  logic             tmo_hit;

  pipe_stall_ctrl_hazard_detect #(
    .LOAD_OP (LOAD_OP)
  ) u_hazard (
    .id_inst  (id_inst),
    .exe_inst (exe_inst),
    .load_use (load_use),
    .is_md    (is_md)
  );

  assign mem_stall = dmem_req & ~dmem_ready;
  assign md_fin    = md_done | md_done_seen;
  assign tmo_hit   = (state == ST_MEM_WAIT) && !dmem_ready && (timer == TMO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next-state: memory stall dominates, then branch, load-use, mult/div.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (mem_stall)                                       state_nxt = ST_MEM_WAIT;
        else if (!exe_branch_taken && !load_use && is_md && !md_busy) state_nxt = ST_MD_WAIT;
      end
      ST_MEM_WAIT: if (dmem_ready || tmo_hit)                state_nxt = ST_RUN;
      ST_MD_WAIT:  if (!mem_stall && md_fin)                 state_nxt = ST_RUN;
      default:                                               state_nxt = ST_RUN;
    endcase
  end

  // Output decode: one control word per cycle from state and live inputs.
  always_comb begin
    ctrl = CTRL_GO;
    case (state)
      ST_RUN: begin
        if (mem_stall)             ctrl = CTRL_FREEZE;
        else if (exe_branch_taken) ctrl = CTRL_FLUSH;
        else if (load_use)         ctrl = CTRL_HOLD_FRONT;
        else if (is_md) begin
          ctrl          = CTRL_HOLD_FRONT;
          ctrl.md_start = !md_busy;
        end
      end
      ST_MEM_WAIT: if (!(dmem_ready || tmo_hit)) ctrl = CTRL_FREEZE;
      ST_MD_WAIT: begin
        if (mem_stall)    ctrl = CTRL_FREEZE;
        else if (!md_fin) ctrl = CTRL_HOLD_FRONT;
      end
      default:            ctrl = CTRL_GO;
    endcase
  end

  assign pc_we      = ctrl.pc_we;
  assign id_we      = ctrl.id_we;
  assign exe_we     = ctrl.exe_we;
  assign mem_we     = ctrl.mem_we;
  assign wb_we      = ctrl.wb_we;
  assign id_flush   = ctrl.id_flush;
  assign exe_bubble = ctrl.exe_bubble;
  assign md_start   = ctrl.md_start;

  // Wait timer, latched mult/div completion, sticky timeout and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      md_done_seen <= 1'b0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (state == ST_RUN && mem_stall) timer <= '0;
      else if (state == ST_MEM_WAIT)    timer <= timer + TMR_W'(1);

      if (tmo_hit) mem_timeout <= 1'b1;

      // A done pulse arriving while memory freezes the pipe must not be lost.
      if (state == ST_MD_WAIT) begin
        if (mem_stall) begin
          if (md_done) md_done_seen <= 1'b1;
        end else if (md_fin) begin
          md_done_seen <= 1'b0;
        end
      end

      if (!ctrl.pc_we && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios then random traffic.
// Expected behaviour comes from a cycle-level reference model of the pipeline actions.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_inst = 32'h0, exe_inst = 32'h0;
  logic        exe_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic        md_busy = 1'b0, md_done = 1'b0;
  logic        pc_we, id_we, exe_we, mem_we, wb_we, id_flush, exe_bubble, md_start, mem_timeout;
  logic [31:0] stall_cycles;

  pipe_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .exe_inst(exe_inst),
    .exe_branch_taken(exe_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .md_busy(md_busy), .md_done(md_done), .pc_we(pc_we), .id_we(id_we), .exe_we(exe_we),
    .mem_we(mem_we), .wb_we(wb_we), .id_flush(id_flush), .exe_bubble(exe_bubble),
    .md_start(md_start), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_LW5   = 32'h8C05_0000;  // lw $5,0($0)
  localparam logic [31:0] I_LW0   = 32'h8C00_0000;  // lw $0,0($0)
  localparam logic [31:0] I_ADD5  = 32'h00A1_3020;  // add $6,$5,$1
  localparam logic [31:0] I_ADD0  = 32'h0001_3020;  // add $6,$0,$1
  localparam logic [31:0] I_MULT  = 32'h00A6_0018;  // mult $5,$6
  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam int          TIMEOUT = 16;

  typedef enum int {A_GO, A_FREEZE, A_FRONT, A_FLUSH} act_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the pipeline is waiting on, not how the RTL encodes it.
  bit          waiting_mem, waiting_md, done_pending, timed_out;
  int          frozen_run;
  longint      stalls;
  act_t        exp_act;
  bit          exp_start;
  int          start_cnt, go_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_load_use(input logic [31:0] idi, input logic [31:0] exi);
    logic [4:0] dst;
    dst = exi[20:16];
    return (exi[31:26] == 6'h23) && (dst != 5'd0) && (dst == idi[25:21] || dst == idi[20:16]);
  endfunction

  function automatic bit ref_is_md(input logic [31:0] idi);
    return (idi[31:26] == 6'h00) && (idi[5:0] >= 6'h18) && (idi[5:0] <= 6'h1B);
  endfunction

  function automatic logic [8:0] act_vec(input act_t a, input bit st, input bit tmo);
    logic [6:0] v;
    case (a)
      A_GO:     v = 7'b11111_00;
      A_FREEZE: v = 7'b00000_00;
      A_FRONT:  v = 7'b00111_01;
      default:  v = 7'b11111_11;
    endcase
    return {v, st, tmo};
  endfunction

  // Decide this cycle's action from model state and live inputs; commit at the edge.
  task automatic step(input string tag);
    bit mstall;
    bit n_mem, n_md, n_pend, n_to;
    int n_frozen;
    mstall = dmem_req && !dmem_ready;
    n_mem = waiting_mem; n_md = waiting_md; n_pend = done_pending; n_to = timed_out;
    n_frozen = frozen_run;
    exp_start = 1'b0;
    if (waiting_mem) begin
      if (dmem_ready) begin exp_act = A_GO; n_mem = 0; end
      else if (frozen_run >= TIMEOUT) begin exp_act = A_GO; n_mem = 0; n_to = 1; end
      else begin exp_act = A_FREEZE; n_frozen = frozen_run + 1; end
    end else if (waiting_md) begin
      if (mstall) begin exp_act = A_FREEZE; if (md_done) n_pend = 1; end
      else if (md_done || done_pending) begin exp_act = A_GO; n_md = 0; n_pend = 0; end
      else exp_act = A_FRONT;
    end else begin
      if (mstall) begin exp_act = A_FREEZE; n_mem = 1; n_frozen = 1; end
      else if (exe_branch_taken) exp_act = A_FLUSH;
      else if (ref_load_use(id_inst, exe_inst)) exp_act = A_FRONT;
      else if (ref_is_md(id_inst)) begin
        exp_act = A_FRONT;
        if (!md_busy) begin exp_start = 1'b1; n_md = 1; end
      end else exp_act = A_GO;
    end
    @(negedge clk);
    chk({tag, ".outs"},
        {23'd0, pc_we, id_we, exe_we, mem_we, wb_we, id_flush, exe_bubble, md_start, mem_timeout},
        {23'd0, act_vec(exp_act, exp_start, timed_out)});
    chk({tag, ".stalls"}, stall_cycles, stalls[31:0]);
    if (md_start) start_cnt++;
    if (pc_we) go_cnt++;
    @(posedge clk);
    if (rst_n) begin
      if ((exp_act == A_FREEZE || exp_act == A_FRONT) && stalls < 64'hFFFF_FFFF) stalls++;
      waiting_mem = n_mem; waiting_md = n_md; done_pending = n_pend; timed_out = n_to;
      frozen_run = n_frozen;
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] idi, input logic [31:0] exi, input bit br,
                       input bit req, input bit rdy, input bit busy, input bit done);
    id_inst = idi; exe_inst = exi; exe_branch_taken = br;
    dmem_req = req; dmem_ready = rdy; md_busy = busy; md_done = done;
  endtask

  task automatic model_reset();
    waiting_mem = 0; waiting_md = 0; done_pending = 0; timed_out = 0;
    frozen_run = 0; stalls = 0;
  endtask

  function automatic logic [31:0] rand_inst(input bit exe_side);
    logic [4:0] rs, rt;
    logic [5:0] fn;
    int k;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    k  = $urandom_range(0, 9);
    if (exe_side && k < 5) return {6'h23, rs, rt, 16'h0010};
    if (k < 3) begin
      fn = 6'(6'h18 + $urandom_range(0, 3));
      return {6'h00, rs, rt, 10'd0, fn};
    end
    if (k < 8) return {6'h00, rs, rt, 5'd7, 5'd0, 6'h20};
    return $urandom();
  endfunction

  longint s0;

  initial begin
    model_reset();
    drive(I_NOP, I_NOP, 0, 0, 0, 0, 0);
    #2;
    chk("rst.stalls", stall_cycles, 32'd0);
    chk("rst.timeout", {31'd0, mem_timeout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle");

    // Load-use: one cycle front stall, then normal flow.
    drive(I_ADD5, I_LW5, 0, 0, 0, 0, 0); step("lu");
    drive(I_ADD5, I_NOP, 0, 0, 0, 0, 0); step("lu_after");
    chk("lu.stalls", stall_cycles, 32'd1);

    // Load into $0 is not a hazard.
    drive(I_ADD0, I_LW0, 0, 0, 0, 0, 0); step("lu_r0");

    // Branch overrides load-use; stall count unchanged.
    s0 = stalls;
    drive(I_ADD5, I_LW5, 1, 0, 0, 0, 0); step("br");
    chk("br.stalls", stall_cycles, s0[31:0]);

    // Memory wait of three cycles, released on the ready cycle.
    s0 = stalls;
    for (int i = 0; i < 3; i++) begin
      drive(I_NOP, I_NOP, 0, 1, 0, 0, 0); step("mem3");
    end
    drive(I_NOP, I_NOP, 0, 1, 1, 0, 0); step("mem3_rel");
    chk("mem3.stalls", stall_cycles, 32'(s0 + 3));
    chk("mem3.no_tmo", {31'd0, mem_timeout}, 32'd0);

    // Memory never ready: forced release after the timeout, sticky flag.
    s0 = stalls;
    go_cnt = 0;
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      drive(I_NOP, I_NOP, 0, 1, 0, 0, 0); step("tmo");
    end
    chk("tmo.stalls", stall_cycles, 32'(s0 + TIMEOUT));
    chk("tmo.release_cnt", go_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      drive(I_NOP, I_NOP, 0, 0, 0, 0, 0); step("tmo_sticky");
    end
    chk("tmo.sticky", {31'd0, mem_timeout}, 32'd1);

    // Multiply with a two-cycle memory stall overlapping the done pulse.
    start_cnt = 0; go_cnt = 0;
    drive(I_MULT, I_NOP, 0, 0, 0, 0, 0); step("md_start");
    for (int c = 1; c <= 9; c++) begin
      drive(I_MULT, I_NOP, 0, (c == 7 || c == 8 || c == 9), (c == 9), 1, (c == 8));
      step("md_wait");
    end
    drive(I_NOP, I_NOP, 0, 0, 0, 0, 0); step("md_after");
    chk("md.start_cnt", start_cnt, 1);
    chk("md.release_cnt", go_cnt, 2);

    // Mult/div op while the unit is busy: stall without a start pulse.
    drive(I_MULT, I_NOP, 0, 0, 0, 1, 0); step("md_busy");
    drive(I_NOP, I_NOP, 0, 0, 0, 0, 0); step("md_busy_after");

    // Reset in the middle of a mult/div wait abandons it.
    drive(I_MULT, I_NOP, 0, 0, 0, 0, 0); step("md_pre_rst");
    drive(I_NOP, I_NOP, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.stalls", stall_cycles, 32'd0);
    chk("rst_mid.timeout", {31'd0, mem_timeout}, 32'd0);
    step("in_rst");
    rst_n = 1'b1;
    drive(I_NOP, I_NOP, 0, 0, 0, 0, 1); step("post_rst");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive(rand_inst(0), rand_inst(1), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
